// File: rtl/ptmch_trg_gen.sv
// SPI-NAND instruction-match trigger generator.
// Snoops a mode-0 SPI bus, captures the first byte of each CS-low frame as the
// opcode, matches it against NUM_CH opcode/mask channels and emits per-channel
// trigger pulses of programmable length at opcode capture or at frame end.
module ptmch_trg_gen #(
    parameter int NUM_CH   = 8,
    parameter int SYNC_STG = 2,
    parameter int PLS_CW   = 8
) (
    input  logic                  CLK160M,
    input  logic                  RESET_N,
    input  logic                  SPI_CS,
    input  logic                  SPI_CLK,
    input  logic                  SPI_MOSI,
    input  logic [NUM_CH-1:0]     CFG_EN,
    input  logic [NUM_CH-1:0]     CFG_MODE,
    input  logic [NUM_CH*8-1:0]   CFG_OPCODE,
    input  logic [NUM_CH*8-1:0]   CFG_MASK,
    input  logic [PLS_CW-1:0]     CFG_PLS_LEN,
    output logic [NUM_CH-1:0]     TRG_PLS,
    output logic [7:0]            INST_CODE,
    output logic                  INST_VLD,
    output logic                  SHORT_FRM
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_HOLD  = 2'b10;

    localparam logic [PLS_CW-1:0] CNT_ONE = {{(PLS_CW-1){1'b0}}, 1'b1};

    // Synchronisers and edge-detect delay flops
    logic [SYNC_STG-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STG-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STG-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STG-1:0] flush_q, flush_d;
    logic                cs_dly_q, cs_dly_d;
    logic                clk_dly_q, clk_dly_d;
    logic                armed_q, armed_d;
    logic                cs_s, clk_s, mosi_s;
    logic                clk_rise, cs_fall, cs_rise;

    // Frame FSM
    logic [1:0]          state_q, state_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [6:0]          shift_q, shift_d;
    logic [7:0]          code_q, code_d;
    logic                vld_q, vld_d;
    logic                short_q, short_d;
    logic [NUM_CH-1:0]   match_q, match_d;
    logic [NUM_CH-1:0]   match_now;
    logic [7:0]          new_code;

    // Per-frame configuration shadow
    logic [NUM_CH-1:0]   sh_en_q, sh_en_d;
    logic [NUM_CH-1:0]   sh_mode_q, sh_mode_d;
    logic [NUM_CH*8-1:0] sh_op_q, sh_op_d;
    logic [NUM_CH*8-1:0] sh_mask_q, sh_mask_d;
    logic [PLS_CW-1:0]   sh_len_q, sh_len_d;

    // Pulse generators
    logic [NUM_CH-1:0]        act_q, act_d;
    logic [NUM_CH*PLS_CW-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0]        fire;
    logic                     hold_end;

    // Pin synchronisation and edge detection
    always_comb begin
        cs_sync_d   = {cs_sync_q[SYNC_STG-2:0], SPI_CS};
        clk_sync_d  = {clk_sync_q[SYNC_STG-2:0], SPI_CLK};
        mosi_sync_d = {mosi_sync_q[SYNC_STG-2:0], SPI_MOSI};
        flush_d     = {flush_q[SYNC_STG-2:0], 1'b1};
        cs_s        = cs_sync_q[SYNC_STG-1];
        clk_s       = clk_sync_q[SYNC_STG-1];
        mosi_s      = mosi_sync_q[SYNC_STG-1];
        cs_dly_d    = cs_s;
        clk_dly_d   = clk_s;
        // After reset the chain holds idle values until flushed; a frame may only
        // start once CS has genuinely been seen high, so a CS held low across
        // reset is not mistaken for a fresh falling edge.
        armed_d     = armed_q | (flush_q[SYNC_STG-1] & cs_s);
        clk_rise    = clk_s & ~clk_dly_q;
        cs_fall     = ~cs_s & cs_dly_q & armed_q;
        cs_rise     = cs_s & ~cs_dly_q;
    end

    // Frame FSM: opcode capture, match evaluation and config shadowing
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        code_d    = code_q;
        vld_d     = 1'b0;
        short_d   = 1'b0;
        match_d   = match_q;
        sh_en_d   = sh_en_q;
        sh_mode_d = sh_mode_q;
        sh_op_d   = sh_op_q;
        sh_mask_d = sh_mask_q;
        sh_len_d  = sh_len_q;
        new_code  = {shift_q, mosi_s};
        match_now = '0;
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            match_now[n] = sh_en_q[n] &
                (((new_code ^ sh_op_q[n*8 +: 8]) & sh_mask_q[n*8 +: 8]) == 8'h00);
        end
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d   = ST_SHIFT;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    sh_en_d   = CFG_EN;
                    sh_mode_d = CFG_MODE;
                    sh_op_d   = CFG_OPCODE;
                    sh_mask_d = CFG_MASK;
                    sh_len_d  = CFG_PLS_LEN;
                end
            end
            ST_SHIFT: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                    short_d = 1'b1;
                end else if (clk_rise) begin
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_HOLD;
                        code_d  = new_code;
                        vld_d   = 1'b1;
                        match_d = match_now;
                    end else begin
                        shift_d   = {shift_q[5:0], mosi_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_HOLD: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Per-channel pulse counters with retrigger
    always_comb begin
        act_d    = act_q;
        cnt_d    = cnt_q;
        fire     = '0;
        hold_end = (state_q == ST_HOLD) && cs_rise;
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            fire[n] = match_q[n] & (sh_mode_q[n] ? hold_end : vld_q);
            if (fire[n]) begin
                act_d[n]                   = 1'b1;
                cnt_d[n*PLS_CW +: PLS_CW]  = sh_len_q;
            end else if (act_q[n]) begin
                if (cnt_q[n*PLS_CW +: PLS_CW] == '0) begin
                    act_d[n] = 1'b0;
                end else begin
                    cnt_d[n*PLS_CW +: PLS_CW] = cnt_q[n*PLS_CW +: PLS_CW] - CNT_ONE;
                end
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge CLK160M) begin
        if (!RESET_N) begin
            cs_sync_q   <= '1;
            clk_sync_q  <= '0;
            mosi_sync_q <= '0;
            flush_q     <= '0;
            cs_dly_q    <= 1'b1;
            clk_dly_q   <= 1'b0;
            armed_q     <= 1'b0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            code_q      <= '0;
            vld_q       <= 1'b0;
            short_q     <= 1'b0;
            match_q     <= '0;
            sh_en_q     <= '0;
            sh_mode_q   <= '0;
            sh_op_q     <= '0;
            sh_mask_q   <= '0;
            sh_len_q    <= '0;
            act_q       <= '0;
            cnt_q       <= '0;
        end else begin
            cs_sync_q   <= cs_sync_d;
            clk_sync_q  <= clk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            flush_q     <= flush_d;
            cs_dly_q    <= cs_dly_d;
            clk_dly_q   <= clk_dly_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            code_q      <= code_d;
            vld_q       <= vld_d;
            short_q     <= short_d;
            match_q     <= match_d;
            sh_en_q     <= sh_en_d;
            sh_mode_q   <= sh_mode_d;
            sh_op_q     <= sh_op_d;
            sh_mask_q   <= sh_mask_d;
            sh_len_q    <= sh_len_d;
            act_q       <= act_d;
            cnt_q       <= cnt_d;
        end
    end

    assign TRG_PLS   = act_q;
    assign INST_CODE = code_q;
    assign INST_VLD  = vld_q;
    assign SHORT_FRM = short_q;

endmodule

// File: tb/tb_ptmch_trg_gen.sv
// Self-checking bench for ptmch_trg_gen: transaction-level model predicting
// every output per cycle, directed scenarios plus randomized frames.
`timescale 1ns/1ps
module tb_ptmch_trg_gen;

    localparam int NUM_CH   = 8;
    localparam int SYNC_STG = 2;
    localparam int PLS_CW   = 8;
    localparam int MAXC     = 65536;
    localparam int LAT      = SYNC_STG + 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 spi_cs, spi_clk, spi_mosi;
    logic [NUM_CH-1:0]    cfg_en, cfg_mode;
    logic [NUM_CH*8-1:0]  cfg_op, cfg_mask;
    logic [PLS_CW-1:0]    cfg_len;
    logic [NUM_CH-1:0]    trg;
    logic [7:0]           code;
    logic                 vld, short_frm;

    always #5 clk = ~clk;

    ptmch_trg_gen #(.NUM_CH(NUM_CH), .SYNC_STG(SYNC_STG), .PLS_CW(PLS_CW)) dut (
        .CLK160M(clk), .RESET_N(rst_n), .SPI_CS(spi_cs), .SPI_CLK(spi_clk),
        .SPI_MOSI(spi_mosi), .CFG_EN(cfg_en), .CFG_MODE(cfg_mode),
        .CFG_OPCODE(cfg_op), .CFG_MASK(cfg_mask), .CFG_PLS_LEN(cfg_len),
        .TRG_PLS(trg), .INST_CODE(code), .INST_VLD(vld), .SHORT_FRM(short_frm)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected output per cycle index
    bit [NUM_CH-1:0] exp_trg  [MAXC];
    bit [7:0]        exp_code [MAXC];
    bit              exp_vld  [MAXC];
    bit              exp_short[MAXC];

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_on && cyc < MAXC) begin
            chk("trg_pls",   32'(trg),       32'(exp_trg[cyc]));
            chk("inst_vld",  32'(vld),       32'(exp_vld[cyc]));
            chk("short_frm", 32'(short_frm), 32'(exp_short[cyc]));
            chk("inst_code", 32'(code),      32'(exp_code[cyc]));
        end
    end

    // Observation counters used by the literal checks
    int vld_cnt, short_cnt, vld_cyc, run0, maxrun0;
    int hi_cnt[NUM_CH];
    int first_rise[NUM_CH];

    always @(negedge clk) begin
        if (chk_on) begin
            if (vld === 1'b1) begin vld_cnt++; vld_cyc = cyc; end
            if (short_frm === 1'b1) short_cnt++;
            for (int c = 0; c < NUM_CH; c++) begin
                if (trg[c] === 1'b1) begin
                    hi_cnt[c]++;
                    if (first_rise[c] < 0) first_rise[c] = cyc;
                end
            end
            if (trg[0] === 1'b1) run0++; else run0 = 0;
            if (run0 > maxrun0) maxrun0 = run0;
        end
    end

    task automatic clr_mon();
        @(posedge clk);
        vld_cnt = 0; short_cnt = 0; vld_cyc = -1; run0 = 0; maxrun0 = 0;
        for (int c = 0; c < NUM_CH; c++) begin hi_cnt[c] = 0; first_rise[c] = -1; end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // A pulse fired at cycle s lasts len+1 cycles and replaces any running one
    task automatic mark(input int ch, input int s, input int len);
        for (int c = s; c < s + 300 && c < MAXC; c++) exp_trg[c][ch] = 1'b0;
        for (int c = s; c <= s + len && c < MAXC; c++) exp_trg[c][ch] = 1'b1;
    endtask

    // Drive one frame (data MSB first) and record its expected effects
    task automatic frame(input int nbits, input logic [31:0] data, input int h,
                         input int mid_bit, input int mid_ch, input logic [7:0] mid_op,
                         output int k8, output int kc);
        logic [NUM_CH-1:0]   s_en   = cfg_en;
        logic [NUM_CH-1:0]   s_mode = cfg_mode;
        logic [NUM_CH*8-1:0] s_op   = cfg_op;
        logic [NUM_CH*8-1:0] s_mask = cfg_mask;
        int                  s_len  = int'(cfg_len);
        logic [7:0]          op     = 8'h00;
        logic [NUM_CH-1:0]   hit    = '0;
        k8 = -1;
        spi_cs = 1'b0;
        idle(h);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = data[31-i];
            idle(h);
            spi_clk = 1'b1;
            if (i < 8) op = {op[6:0], data[31-i]};
            if (i == 7) begin
                k8 = cyc;
                exp_vld[k8 + LAT] = 1'b1;
                for (int c = k8 + LAT; c < MAXC; c++) exp_code[c] = op;
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    hit[ch] = s_en[ch] && (((op ^ s_op[ch*8 +: 8]) & s_mask[ch*8 +: 8]) == 8'h00);
                    if (hit[ch] && !s_mode[ch]) mark(ch, k8 + LAT + 1, s_len);
                end
            end
            if (i == mid_bit) cfg_op[mid_ch*8 +: 8] = mid_op;
            idle(h);
            spi_clk = 1'b0;
        end
        idle(h);
        spi_cs   = 1'b1;
        spi_mosi = 1'b0;
        kc = cyc;
        if (nbits < 8) begin
            exp_short[kc + LAT] = 1'b1;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++)
                if (hit[ch] && s_mode[ch]) mark(ch, kc + LAT, s_len);
        end
    endtask

    int k8a, kca, k8b, kcb, tot, pick;
    logic [7:0] rop;

    initial begin
        rst_n = 1'b0;
        spi_cs = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
        cfg_en = '0; cfg_mode = '0; cfg_op = '0; cfg_mask = '0; cfg_len = '0;
        @(negedge clk);
        chk_on = 1'b1;
        clr_mon();

        // 1. Reset with SPI activity, then a plain frame
        repeat (4) begin
            @(negedge clk);
            spi_cs = 1'($urandom); spi_clk = 1'($urandom); spi_mosi = 1'($urandom);
        end
        @(negedge clk);
        spi_cs = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
        idle(4);
        chk("rst_trg", 32'(trg), 32'h0);
        chk("rst_code", 32'(code), 32'h0);
        chk("rst_vld_short", {30'h0, vld, short_frm}, 32'h0);
        rst_n = 1'b1;
        idle(5);
        clr_mon();
        frame(8, 32'h13000000, 3, -1, 0, 8'h00, k8a, kca);
        idle(10);
        chk("t1_code", 32'(code), 32'h13);
        chk("t1_vld_cnt", vld_cnt, 1);

        // 2. Mode-0 match on ch0, 16-cycle pulse
        cfg_en = 8'h01; cfg_mode = '0; cfg_op[7:0] = 8'h10; cfg_mask[7:0] = 8'hFF; cfg_len = 8'd15;
        clr_mon();
        frame(8, 32'h10000000, 4, -1, 0, 8'h00, k8a, kca);
        idle(40);
        chk("t2_len", hi_cnt[0], 16);
        chk("t2_start", first_rise[0], vld_cyc + 1);
        tot = 0;
        for (int c = 1; c < NUM_CH; c++) tot += hi_cnt[c];
        chk("t2_others", tot, 0);

        // 3. Mask and multi-channel
        cfg_en = 8'h0F;
        cfg_op[15:8] = 8'h0F; cfg_mask[15:8] = 8'hFB;
        cfg_op[23:16] = 8'hD8; cfg_mask[23:16] = 8'hFF;
        cfg_op[31:24] = 8'h5A; cfg_mask[31:24] = 8'h00;
        clr_mon();
        frame(16, 32'h0BCD0000, 3, -1, 0, 8'h00, k8a, kca);
        idle(40);
        chk("t3_ch1_len", hi_cnt[1], 16);
        chk("t3_same_cycle", first_rise[3], first_rise[1]);
        chk("t3_ch2_quiet", hi_cnt[2], 0);

        // 4. Mode-1 channel fires at frame end
        cfg_en = 8'h1F; cfg_mode = 8'h10; cfg_op[39:32] = 8'h1F; cfg_mask[39:32] = 8'hFF;
        clr_mon();
        frame(32, 32'h1F123456, 3, -1, 0, 8'h00, k8a, kca);
        idle(40);
        chk("t4_start", first_rise[4], kca + SYNC_STG + 1);
        chk("t4_len", hi_cnt[4], 16);

        // 5. Short frame
        clr_mon();
        frame(5, 32'hA8000000, 3, -1, 0, 8'h00, k8a, kca);
        idle(40);
        chk("t5_short_cnt", short_cnt, 1);
        chk("t5_vld_cnt", vld_cnt, 0);
        chk("t5_code_kept", 32'(code), 32'h1F);
        tot = 0;
        for (int c = 0; c < NUM_CH; c++) tot += hi_cnt[c];
        chk("t5_no_trg", tot, 0);

        // 6. Retrigger across back-to-back frames; mid-frame opcode change ignored
        cfg_en = 8'h01; cfg_mode = '0; cfg_op[7:0] = 8'h10; cfg_len = 8'd80;
        clr_mon();
        frame(8, 32'h10000000, 3, -1, 0, 8'h00, k8a, kca);
        idle(3);
        frame(8, 32'h10000000, 3, 2, 0, 8'h55, k8b, kcb);
        idle(120);
        chk("t6_run", maxrun0, (k8b - k8a) + 81);
        chk("t6_total", hi_cnt[0], (k8b - k8a) + 81);

        // Randomized frames
        for (int f = 0; f < 60; f++) begin
            cfg_en = NUM_CH'($urandom);
            cfg_mode = NUM_CH'($urandom);
            cfg_op = {$urandom, $urandom};
            for (int c = 0; c < NUM_CH; c++) begin
                pick = int'($urandom_range(0, 3));
                cfg_mask[c*8 +: 8] = (pick < 2) ? 8'hFF : (pick == 2 ? 8'($urandom) : 8'($urandom) & 8'hF0);
            end
            cfg_len = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 40));
            pick = int'($urandom_range(0, NUM_CH - 1));
            rop = ($urandom_range(0, 3) == 0) ? 8'($urandom) : cfg_op[pick*8 +: 8];
            frame(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(8, 24)),
                  {rop, 24'($urandom)}, int'($urandom_range(3, 5)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1,
                  int'($urandom_range(0, NUM_CH - 1)), 8'($urandom), k8a, kca);
            idle(int'($urandom_range(3, 12)));
        end
        idle(300);
        chk_on = 1'b0;
        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
